// File: rtl/trace_nop_event_extractor.sv
// Per-core trace front end: shadows GPR r3 and turns l.nop simulation hooks
// (exit/report/putc) into typed events delivered through a small FIFO stream.
module trace_nop_event_extractor #(
    parameter int          ID         = 0,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [15:0] NOP_EXIT   = 16'h0001,
    parameter logic [15:0] NOP_REPORT = 16'h0002,
    parameter logic [15:0] NOP_PUTC   = 16'h0004
) (
    input  logic                          clk,
    input  logic                          rst_sys_n,
    input  logic                          stm_enable,
    input  logic [31:0]                   stm_insn,
    input  logic                          stm_wben,
    input  logic [4:0]                    stm_wbreg,
    input  logic [31:0]                   stm_wbdata,
    output logic                          evt_valid,
    input  logic                          evt_ready,
    output logic [1:0]                    evt_type,
    output logic [31:0]                   evt_data,
    output logic [7:0]                    evt_core,
    output logic [31:0]                   r3,
    output logic                          terminated,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int          AW   = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL = (AW + 1)'(FIFO_DEPTH);

    localparam logic [1:0] TYPE_EXIT   = 2'd0;
    localparam logic [1:0] TYPE_REPORT = 2'd1;
    localparam logic [1:0] TYPE_PUTC   = 2'd2;

    logic [31:0]   r_r3;
    logic          r_terminated;
    logic          r_overflow;
    logic [AW:0]   r_level;
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [1:0]    r_mem_type [FIFO_DEPTH];
    logic [31:0]   r_mem_data [FIFO_DEPTH];

    logic          w_wb_r3;
    logic          w_is_nop;
    logic          w_hit;
    logic [1:0]    w_type;
    logic [31:0]   w_data;
    logic          w_capture;
    logic          w_full;
    logic          w_pop;
    logic          w_push;

    assign w_wb_r3  = stm_enable && stm_wben && (stm_wbreg == 5'd3);
    assign w_is_nop = stm_enable && (stm_insn[31:16] == 16'h1500);

    // Exit takes precedence if parameters are ever configured to collide.
    always_comb begin
        w_hit  = 1'b0;
        w_type = TYPE_EXIT;
        if (w_is_nop) begin
            if (stm_insn[15:0] == NOP_EXIT) begin
                w_hit  = 1'b1;
                w_type = TYPE_EXIT;
            end else if (stm_insn[15:0] == NOP_REPORT) begin
                w_hit  = 1'b1;
                w_type = TYPE_REPORT;
            end else if (stm_insn[15:0] == NOP_PUTC) begin
                w_hit  = 1'b1;
                w_type = TYPE_PUTC;
            end
        end
    end

    assign w_data    = w_wb_r3 ? stm_wbdata : r_r3;
    assign w_capture = w_hit && !r_terminated;
    assign w_full    = (r_level == FULL);
    assign w_pop     = evt_valid && evt_ready;
    assign w_push    = w_capture && (!w_full || w_pop);

    always_ff @(posedge clk or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            r_r3         <= '0;
            r_terminated <= 1'b0;
            r_overflow   <= 1'b0;
            r_level      <= '0;
            r_rd_ptr     <= '0;
            r_wr_ptr     <= '0;
        end else begin
            if (w_wb_r3)
                r_r3 <= stm_wbdata;
            // A dropped exit still terminates the core.
            if (w_capture && (w_type == TYPE_EXIT))
                r_terminated <= 1'b1;
            if (w_capture && !w_push)
                r_overflow <= 1'b1;
            if (w_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // Storage needs no reset; validity is tracked by the level counter.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_type[r_wr_ptr] <= w_type;
            r_mem_data[r_wr_ptr] <= w_data;
        end
    end

    assign evt_valid  = (r_level != '0);
    assign evt_type   = r_mem_type[r_rd_ptr];
    assign evt_data   = r_mem_data[r_rd_ptr];
    assign evt_core   = 8'(ID);
    assign r3         = r_r3;
    assign terminated = r_terminated;
    assign overflow   = r_overflow;
    assign fifo_level = r_level;

endmodule

// File: tb/tb_trace_nop_event_extractor.sv
// Directed bench for trace_nop_event_extractor: shadow r3, hook decode,
// bypass, backpressure/overflow, exit gating and asynchronous reset.
module tb_trace_nop_event_extractor;

    localparam int ID = 7;

    logic        clk = 1'b0;
    logic        rst_sys_n = 1'b0;
    logic        stm_enable = 1'b0;
    logic [31:0] stm_insn = '0;
    logic        stm_wben = 1'b0;
    logic [4:0]  stm_wbreg = '0;
    logic [31:0] stm_wbdata = '0;
    logic        evt_valid;
    logic        evt_ready = 1'b0;
    logic [1:0]  evt_type;
    logic [31:0] evt_data;
    logic [7:0]  evt_core;
    logic [31:0] r3;
    logic        terminated;
    logic        overflow;
    logic [3:0]  fifo_level;

    int testsRun = 0;
    int testsFailed = 0;

    trace_nop_event_extractor #(.ID(ID), .FIFO_DEPTH(8)) dut (
        .clk(clk), .rst_sys_n(rst_sys_n),
        .stm_enable(stm_enable), .stm_insn(stm_insn), .stm_wben(stm_wben),
        .stm_wbreg(stm_wbreg), .stm_wbdata(stm_wbdata),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_type(evt_type),
        .evt_data(evt_data), .evt_core(evt_core), .r3(r3),
        .terminated(terminated), .overflow(overflow), .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    // One trace entry for one cycle; inputs change 1 time unit after an edge.
    task automatic trace(input logic [31:0] insn, input logic wben,
                         input logic [4:0] wbreg, input logic [31:0] wbdata);
        stm_enable = 1'b1;
        stm_insn   = insn;
        stm_wben   = wben;
        stm_wbreg  = wbreg;
        stm_wbdata = wbdata;
        @(posedge clk); #1;
        stm_enable = 1'b0;
        stm_wben   = 1'b0;
    endtask

    task automatic doReset();
        evt_ready = 1'b0;
        stm_enable = 1'b0;
        rst_sys_n = 1'b0;
        @(posedge clk); #1;
        rst_sys_n = 1'b1;
    endtask

    task automatic test_reset();
        doReset();
        testsRun++;
        if (evt_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_valid got %b expected 0", evt_valid); end
        testsRun++;
        if (fifo_level !== 4'd0) begin testsFailed++; $display("[TB] FAIL reset_level got %0d expected 0", fifo_level); end
        testsRun++;
        if (r3 !== 32'h0) begin testsFailed++; $display("[TB] FAIL reset_r3 got %h expected 0", r3); end
        testsRun++;
        if ({terminated, overflow} !== 2'b00) begin testsFailed++; $display("[TB] FAIL reset_flags got %b expected 00", {terminated, overflow}); end
    endtask

    task automatic test_putc_basic();
        evt_ready = 1'b1;
        trace(32'hE0000000, 1'b1, 5'd3, 32'h41);
        testsRun++;
        if (r3 !== 32'h41) begin testsFailed++; $display("[TB] FAIL shadow_r3 got %h expected 41", r3); end
        testsRun++;
        if (evt_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL add_no_event got %b expected 0", evt_valid); end
        trace(32'h15000004, 1'b0, 5'd0, 32'h0);
        testsRun++;
        if ({evt_valid, evt_type, evt_data, evt_core} !== {1'b1, 2'd2, 32'h41, 8'd7})
            begin testsFailed++; $display("[TB] FAIL putc_event got v=%b t=%0d d=%h c=%0d expected v=1 t=2 d=41 c=7", evt_valid, evt_type, evt_data, evt_core); end
        @(posedge clk); #1;
        testsRun++;
        if (evt_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL putc_one_cycle got %b expected 0", evt_valid); end
    endtask

    task automatic test_bypass();
        evt_ready = 1'b1;
        trace(32'h15000004, 1'b1, 5'd3, 32'h5A);
        testsRun++;
        if ({evt_valid, evt_type, evt_data} !== {1'b1, 2'd2, 32'h5A})
            begin testsFailed++; $display("[TB] FAIL bypass_event got v=%b t=%0d d=%h expected v=1 t=2 d=5a", evt_valid, evt_type, evt_data); end
        testsRun++;
        if (r3 !== 32'h5A) begin testsFailed++; $display("[TB] FAIL bypass_r3 got %h expected 5a", r3); end
        trace(32'h15000002, 1'b0, 5'd0, 32'h0);
        testsRun++;
        if ({evt_valid, evt_type, evt_data, fifo_level} !== {1'b1, 2'd1, 32'h5A, 4'd1})
            begin testsFailed++; $display("[TB] FAIL report_event got v=%b t=%0d d=%h l=%0d expected v=1 t=1 d=5a l=1", evt_valid, evt_type, evt_data, fifo_level); end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        evt_ready = 1'b0;
        for (int i = 0; i < 8; i++)
            trace(32'h15000004, 1'b1, 5'd3, 32'h30 + i);
        testsRun++;
        if ({fifo_level, overflow} !== {4'd8, 1'b0}) begin testsFailed++; $display("[TB] FAIL fill_8 got l=%0d o=%b expected l=8 o=0", fifo_level, overflow); end
        trace(32'h15000004, 1'b1, 5'd3, 32'h38);
        testsRun++;
        if ({fifo_level, overflow} !== {4'd8, 1'b1}) begin testsFailed++; $display("[TB] FAIL drop_9th got l=%0d o=%b expected l=8 o=1", fifo_level, overflow); end
        evt_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            testsRun++;
            if ({evt_valid, evt_data} !== {1'b1, 32'h30 + i})
                begin testsFailed++; $display("[TB] FAIL drain_%0d got v=%b d=%h expected v=1 d=%h", i, evt_valid, evt_data, 32'h30 + i); end
            @(posedge clk); #1;
        end
        testsRun++;
        if ({evt_valid, fifo_level} !== {1'b0, 4'd0}) begin testsFailed++; $display("[TB] FAIL drained got v=%b l=%0d expected v=0 l=0", evt_valid, fifo_level); end
    endtask

    task automatic test_full_pop();
        doReset();
        for (int i = 0; i < 8; i++)
            trace(32'h15000004, 1'b1, 5'd3, 32'h60 + i);
        evt_ready = 1'b1;
        trace(32'h15000004, 1'b1, 5'd3, 32'h70);
        evt_ready = 1'b0;
        testsRun++;
        if ({fifo_level, overflow, evt_data} !== {4'd8, 1'b0, 32'h61})
            begin testsFailed++; $display("[TB] FAIL full_pop got l=%0d o=%b d=%h expected l=8 o=0 d=61", fifo_level, overflow, evt_data); end
    endtask

    task automatic test_exit();
        doReset();
        evt_ready = 1'b1;
        trace(32'h15000003, 1'b0, 5'd0, 32'h0);
        trace(32'hE0631800, 1'b1, 5'd3, 32'h0);
        testsRun++;
        if (evt_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL nop3_add_no_event got %b expected 0", evt_valid); end
        trace(32'h15000001, 1'b0, 5'd0, 32'h0);
        testsRun++;
        if ({evt_valid, evt_type, evt_data, terminated} !== {1'b1, 2'd0, 32'h0, 1'b1})
            begin testsFailed++; $display("[TB] FAIL exit_event got v=%b t=%0d d=%h term=%b expected v=1 t=0 d=0 term=1", evt_valid, evt_type, evt_data, terminated); end
        @(posedge clk); #1;
        trace(32'h15000004, 1'b1, 5'd3, 32'h99);
        testsRun++;
        if ({evt_valid, r3} !== {1'b0, 32'h99}) begin testsFailed++; $display("[TB] FAIL gated_after_exit got v=%b r3=%h expected v=0 r3=99", evt_valid, r3); end
    endtask

    task automatic test_reset_mid();
        doReset();
        for (int i = 0; i < 8; i++)
            trace(32'h15000004, 1'b1, 5'd3, 32'h20 + i);
        trace(32'h15000001, 1'b0, 5'd0, 32'h0);
        testsRun++;
        if ({fifo_level, overflow, terminated} !== {4'd8, 1'b1, 1'b1})
            begin testsFailed++; $display("[TB] FAIL dropped_exit got l=%0d o=%b term=%b expected l=8 o=1 term=1", fifo_level, overflow, terminated); end
        #2 rst_sys_n = 1'b0;
        #1;
        testsRun++;
        if ({evt_valid, fifo_level, r3, terminated, overflow} !== {1'b0, 4'd0, 32'h0, 1'b0, 1'b0})
            begin testsFailed++; $display("[TB] FAIL async_reset got v=%b l=%0d r3=%h term=%b o=%b expected all 0", evt_valid, fifo_level, r3, terminated, overflow); end
        doReset();
    endtask

    initial begin
        test_reset();
        test_putc_basic();
        test_bypass();
        test_backpressure();
        test_full_pop();
        test_exit();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
